// File: rtl/chan4_seq_if.sv
// chan4_seq_if: groups the frame-control, mux-side and FIFO-side signals of
// chan4_seq. The "master" modport is the sequencer itself; "slave" is the
// surrounding logic (strobe source, latched 4 x 18-bit mux, consumer).
interface chan4_seq_if;
    logic        stb;    // frame start strobe, one cycle wide
    logic [1:0]  s;      // channel select to the latched mux
    logic        ce;     // clock enable of the mux output latch
    logic [17:0] q;      // latched mux output, valid the cycle after ce
    logic [17:0] dout;   // FIFO head data
    logic [1:0]  ch;     // channel tag of dout
    logic        dv;     // dout/ch valid (FIFO not empty)
    logic        rdy;    // consumer ready, pops when dv && rdy
    logic        busy;   // frame scan or its final capture pending
    logic        ovf;    // sticky overflow flag
    logic        clr;    // synchronous clear of ovf

    modport master (
        input  stb, q, rdy, clr,
        output s, ce, dout, ch, dv, busy, ovf
    );

    modport slave (
        output stb, q, rdy, clr,
        input  s, ce, dout, ch, dv, busy, ovf
    );
endinterface

// File: rtl/chan4_seq.sv
// chan4_seq: four-channel scan sequencer. A strobe starts a frame that steps
// the mux select from 0 to NLAST with the latch enable high, the latched mux
// word is captured one cycle later and pushed, tagged with its channel, into
// a small output FIFO that the consumer drains with a valid/ready handshake.
//
// Build option: define CHSEQ_OVF_EN to enable the sticky overflow flag
// (set on dropped samples and on strobes that arrive while busy, cleared by
// clr). Without it ovf is tied low and clr is ignored; dropping, strobe
// rejection and FIFO behaviour are the same in both builds.
module chan4_seq #(
    parameter int NLAST = 3,   // last channel scanned per frame (0..3)
    parameter int DEPTH = 4    // FIFO depth, power of two, 2..16
) (
    input  logic       clk,
    input  logic       rst_n,
    chan4_seq_if.master bus
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------
    state_t      state_reg, state_next;
    logic [1:0]  s_reg, s_next;
    logic        ce_comb;
    logic        busy_comb;
    logic        start;

    // Capture pipeline: ce/s delayed by one cycle to line up with q.
    logic        capv_reg;
    logic [1:0]  capch_reg;

    // A strobe is only honoured when nothing of a previous frame is pending.
    assign busy_comb = (state_reg != IDLE) || capv_reg;
    assign start     = bus.stb && !busy_comb;

    // State and select registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            s_reg     <= 2'd0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
        end
    end

    // Next-state, next-select and latch-enable decode.
    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        ce_comb    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SCAN;
                    s_next     = 2'd0;
                end
            end
            SCAN: begin
                ce_comb = 1'b1;
                if (s_reg == 2'(NLAST)) begin
                    // Select holds at NLAST through FLUSH and IDLE.
                    state_next = FLUSH;
                end else begin
                    s_next = s_reg + 2'd1;
                end
            end
            FLUSH: begin
                // One cycle for the last channel's capture to complete.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture pipeline: a word is latched by the mux at the edge ending a
    // ce cycle, so it is valid on q during the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            capv_reg  <= 1'b0;
            capch_reg <= 2'd0;
        end else begin
            capv_reg  <= ce_comb;
            capch_reg <= s_reg;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [19:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          fifo_empty, fifo_full;
    logic          pop, push_ok, drop;
    logic [19:0]   head;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == (AW+1)'(DEPTH));
    assign pop        = !fifo_empty && bus.rdy;
    // When full, a push only fits if the head leaves at the same edge.
    assign push_ok    = capv_reg && (!fifo_full || pop);
    assign drop       = capv_reg && fifo_full && !pop;

    // Storage write: tag and data go in together; entries need no reset
    // because they are never presented before being written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= {capch_reg, bus.q};
        end
    end

    // Pointers wrap naturally at DEPTH; count is one bit wider so full and
    // empty are distinguishable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Head word is forced to zero while empty so the outputs are never
    // unknown, including straight after reset.
    assign head = fifo_empty ? 20'd0 : mem[rd_ptr_reg];

    // ------------------------------------------------------------------
    // Overflow flag
    // ------------------------------------------------------------------
`ifdef CHSEQ_OVF_EN
    logic ovf_reg;
    logic ovf_event;

    assign ovf_event = drop || (bus.stb && busy_comb);

    // Sticky flag: a new event wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (ovf_event) begin
            ovf_reg <= 1'b1;
        end else if (bus.clr) begin
            ovf_reg <= 1'b0;
        end
    end

    assign bus.ovf = ovf_reg;
`else
    logic unused_ovf_path;
    assign unused_ovf_path = bus.clr ^ drop;
    assign bus.ovf         = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.s    = s_reg;
    assign bus.ce   = ce_comb;
    assign bus.busy = busy_comb;
    assign bus.dv   = !fifo_empty;
    assign bus.ch   = head[19:18];
    assign bus.dout = head[17:0];

endmodule

// File: tb/tb_chan4_seq.sv
// tb_chan4_seq: directed plus randomized checking of chan4_seq against a
// queue-based reference model (frame offsets, FIFO as a queue of tagged
// words). A second instance with NLAST=1 checks the short-scan case.
module tb_chan4_seq;

    localparam int NL0 = 3;
    localparam int DP0 = 4;
    localparam int NL1 = 1;

`ifdef CHSEQ_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    chan4_seq_if b0();
    chan4_seq_if b1();

    chan4_seq #(.NLAST(NL0), .DEPTH(DP0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0.master)
    );

    chan4_seq #(.NLAST(NL1), .DEPTH(4)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.master)
    );

    int total = 0;
    int bad   = 0;

    // Latched mux models: the selected channel word appears on q after ce.
    logic [17:0] frame0 [4];
    logic [17:0] frame1 [4];

    always @(posedge clk) begin
        if (b0.ce === 1'b1) b0.q <= frame0[b0.s];
    end

    always @(posedge clk) begin
        if (b1.ce === 1'b1) b1.q <= frame1[b1.s];
    end

    // Reference model state for instance 0.
    int          edge_cnt = 0;
    int          m_k      = -1000;   // edge at which current frame started
    logic [17:0] m_data [4];
    logic [19:0] mq [$];             // {ch, data}
    logic        m_ovf  = 1'b0;
    logic [1:0]  m_s    = 2'd0;
    logic        m_busy = 1'b0;
    logic        m_ce   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_k    = -1000;
        m_ovf  = 1'b0;
        m_s    = 2'd0;
        m_busy = 1'b0;
        m_ce   = 1'b0;
    endtask

    // Frame started at edge k: channel c is pushed at edge k+2+c, ce is high
    // for the NLAST+1 cycles after edge k, busy one cycle longer.
    task automatic model_edge();
        int c, d;
        bit ev, pop;
        edge_cnt++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ev  = 1'b0;
        pop = (mq.size() > 0) && (b0.rdy == 1'b1);
        c   = edge_cnt - m_k - 2;
        if (pop) void'(mq.pop_front());
        if (c >= 0 && c <= NL0) begin
            if (mq.size() < DP0) mq.push_back({c[1:0], m_data[c]});
            else ev = 1'b1;
        end
        if (b0.stb == 1'b1) begin
            if (m_busy) begin
                ev = 1'b1;
            end else begin
                m_k    = edge_cnt;
                m_data = frame0;
            end
        end
        if (OVF_EN) begin
            if (ev) m_ovf = 1'b1;
            else if (b0.clr == 1'b1) m_ovf = 1'b0;
        end
        d      = edge_cnt - m_k;
        m_ce   = (d >= 0) && (d <= NL0);
        m_busy = (d >= 0) && (d <= NL0 + 1);
        if (m_ce) m_s = d[1:0];
    endtask

    task automatic compare();
        check("ce", b0.ce, m_ce);
        check("s", b0.s, m_s);
        check("busy", b0.busy, m_busy);
        check("ovf", b0.ovf, m_ovf);
        check("dv", b0.dv, mq.size() > 0);
        if (mq.size() > 0) check("word", {b0.ch, b0.dout}, mq[0]);
        else check("dout_known", 32'($isunknown({b0.ch, b0.dout})), 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_frame0(input bit rnd);
        for (int c = 0; c < 4; c++)
            frame0[c] = rnd ? 18'($urandom) : 18'h00100 + 18'(c);
    endtask

    // One-cycle strobe; new mux data only when the strobe will be accepted.
    task automatic strobe0(input bit rnd);
        if (!m_busy) set_frame0(rnd);
        b0.stb = 1'b1;
        tick();
        b0.stb = 1'b0;
    endtask

    logic        ce_seq [10];
    logic [1:0]  s_seq [10];
    logic        busy_seq [10];
    logic [19:0] got1 [$];

    initial begin
        rst_n  = 1'b0;
        b0.stb = 1'b0; b0.rdy = 1'b1; b0.clr = 1'b0;
        b1.stb = 1'b0; b1.rdy = 1'b1; b1.clr = 1'b0;
        set_frame0(1'b0);
        for (int c = 0; c < 4; c++) frame1[c] = 18'd0;

        // Reset state.
        ticks(2);
        check("rst_dout", b0.dout, 0);
        check("rst_ch", b0.ch, 0);

        // Release with strobe already high: first edge starts the frame.
        rst_n = 1'b1;
        strobe0(1'b0);
        ticks(8);

        // Overflow: consumer stalled across two frames.
        b0.rdy = 1'b0;
        strobe0(1'b1);
        ticks(8);
        strobe0(1'b1);
        ticks(8);
        b0.rdy = 1'b1;
        ticks(6);

        b0.clr = 1'b1;
        tick();
        b0.clr = 1'b0;
        tick();

        // Full FIFO with pops overlapping every capture.
        b0.rdy = 1'b0;
        strobe0(1'b1);
        ticks(8);
        strobe0(1'b1);
        tick();
        b0.rdy = 1'b1;
        ticks(10);

        // Early strobe two edges into a frame.
        strobe0(1'b1);
        tick();
        strobe0(1'b1);
        ticks(8);
        b0.clr = 1'b1;
        tick();
        b0.clr = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            b0.stb = ($urandom_range(0, 5) == 0);
            if (b0.stb && !m_busy) set_frame0(1'b1);
            b0.rdy = ($urandom_range(0, 2) != 0);
            b0.clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        b0.stb = 1'b0; b0.rdy = 1'b1; b0.clr = 1'b0;
        ticks(8);

        // Asynchronous reset in the middle of a scan.
        strobe0(1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        ticks(2);
        rst_n = 1'b1;
        strobe0(1'b1);
        ticks(8);

        // Short scan on the NLAST=1 instance.
        for (int c = 0; c < 4; c++) frame1[c] = 18'($urandom);
        b1.stb = 1'b1;
        tick();
        b1.stb = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ce_seq[i]   = b1.ce;
            s_seq[i]    = b1.s;
            busy_seq[i] = b1.busy;
            if (b1.dv) got1.push_back({b1.ch, b1.dout});
            tick();
        end
        check("n1_ce_pattern", {ce_seq[0], ce_seq[1], ce_seq[2], ce_seq[3]}, 4'b1100);
        check("n1_s_pattern", {s_seq[0], s_seq[1], s_seq[2]}, 6'b000101);
        check("n1_busy_pattern", {busy_seq[0], busy_seq[1], busy_seq[2], busy_seq[3]}, 4'b1110);
        check("n1_words", got1.size(), 2);
        if (got1.size() >= 2) begin
            check("n1_w0", got1[0], {2'd0, frame1[0]});
            check("n1_w1", got1[1], {2'd1, frame1[1]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
